// File: rtl/sipo_if.sv
// sipo_if: serial line and parallel receive bus of the sipo UART receiver.
// The master modport is the receiver itself (samples the line, produces words);
// the slave modport is the environment that drives the line and consumes words.
interface sipo_if #(
    parameter int CHAR_W = 8
);
    logic              uart_rx_pin;
    logic [CHAR_W-1:0] rx_data;
    logic              rx_valid;
    logic              framing_error;
    logic              rx_busy;

    modport master (
        input  uart_rx_pin,
        output rx_data,
        output rx_valid,
        output framing_error,
        output rx_busy
    );

    modport slave (
        output uart_rx_pin,
        input  rx_data,
        input  rx_valid,
        input  framing_error,
        input  rx_busy
    );
endinterface

// File: rtl/sipo.sv
// sipo: serial-in, parallel-out UART receiver (start bit, CHAR_W data bits LSB
// first, one stop bit). Companion of the piso transmitter with the same DIVIDER.
// Optional feature macro: SIPO_MAJORITY_VOTE_EN -- each sample point becomes a
// 2-of-3 vote over three consecutive synchronised samples, decided one cycle
// later than the nominal sample point.
module sipo #(
    parameter int DIVIDER = 4096,
    parameter int CHAR_W  = 8
) (
    input logic   clock_50M,
    input logic   reset,
    sipo_if.master rx
);

    localparam int CNT_W = $clog2(DIVIDER);
    localparam int IDX_W = $clog2(CHAR_W + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVIDER - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CHAR_W - 1);
`ifdef SIPO_MAJORITY_VOTE_EN
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(DIVIDER / 2);
`else
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(DIVIDER / 2 - 1);
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CHAR_W-1:0] sh_q, sh_d;
    logic              stop_good_q, stop_good_d;
    logic              stop_bad_q, stop_bad_d;

    logic sync1, sync2, prev;
    logic sample_bit;

`ifdef SIPO_MAJORITY_VOTE_EN
    logic prev2;

    // Two-flop synchroniser plus two delayed copies for the three-sample vote
    always_ff @(posedge clock_50M) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
            prev2 <= 1'b1;
        end else begin
            sync1 <= rx.uart_rx_pin;
            sync2 <= sync1;
            prev  <= sync2;
            prev2 <= prev;
        end
    end

    assign sample_bit = (prev2 & prev) | (prev & sync2) | (prev2 & sync2);
`else
    // Two-flop synchroniser plus a delayed copy for falling-edge detection
    always_ff @(posedge clock_50M) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync1 <= rx.uart_rx_pin;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign sample_bit = sync2;
`endif

    // FSM and datapath registers; outputs lag the stop sample by one cycle
    always_ff @(posedge clock_50M) begin
        if (reset) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            idx_q            <= '0;
            sh_q             <= '0;
            stop_good_q      <= 1'b0;
            stop_bad_q       <= 1'b0;
            rx.rx_data       <= '0;
            rx.rx_valid      <= 1'b0;
            rx.framing_error <= 1'b0;
            rx.rx_busy       <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            idx_q            <= idx_d;
            sh_q             <= sh_d;
            stop_good_q      <= stop_good_d;
            stop_bad_q       <= stop_bad_d;
            rx.rx_valid      <= stop_good_q;
            rx.framing_error <= stop_bad_q;
            rx.rx_busy       <= (state_q != IDLE);
            if (stop_good_q) begin
                rx.rx_data <= sh_q;
            end
        end
    end

    // Next-state logic: edge trigger, mid-start check, data shifting, stop check
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        sh_d        = sh_q;
        stop_good_d = 1'b0;
        stop_bad_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (prev && !sync2) begin
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == START_LAST) begin
                    if (sample_bit) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = '0;
                        idx_d   = '0;
                        state_d = DATA;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    sh_d  = {sample_bit, sh_q[CHAR_W-1:1]};
                    idx_d = idx_q + 1'b1;
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    stop_good_d = sample_bit;
                    stop_bad_d  = !sample_bit;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sipo.sv
// tb_sipo: drives bit-accurate serial frames into sipo (DIVIDER=16, CHAR_W=8)
// and compares the received words, pulses and busy flag against a model that
// decodes the recorded line waveform at the nominal UART sample points.
module tb_sipo;

    localparam int D    = 16;
    localparam int C    = 8;
    localparam int MAXC = 8000;
`ifdef SIPO_MAJORITY_VOTE_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic clock_50M = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    logic [7:0] last_good = 8'h00;

    logic pin_hist [MAXC];
    logic busy_hist [MAXC];
    int         v_cyc [$];
    logic [7:0] v_dat [$];
    int         fe_cyc [$];

    sipo_if #(.CHAR_W(C)) bus ();

    sipo #(.DIVIDER(D), .CHAR_W(C)) dut (
        .clock_50M (clock_50M),
        .reset     (reset),
        .rx        (bus)
    );

    always #5 clock_50M = ~clock_50M;

    // Cycle index equals the number of the most recent rising edge
    always @(posedge clock_50M) cyc <= cyc + 1;

    // Record busy level and output pulses against the edge that produced them
    always @(negedge clock_50M) begin
        if (cyc < MAXC) busy_hist[cyc] = bus.rx_busy;
        if (bus.rx_valid === 1'b1) begin
            v_cyc.push_back(cyc);
            v_dat.push_back(bus.rx_data);
        end
        if (bus.framing_error === 1'b1) fe_cyc.push_back(cyc);
    end

    // Hold the line at v for n cycles, logging the level each edge captures
    task automatic drive_level(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            bus.uart_rx_pin = v;
            if (cyc + 1 < MAXC) pin_hist[cyc + 1] = v;
            @(posedge clock_50M);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit, output int t0);
        t0 = cyc + 1;
        drive_level(1'b0, D);
        for (int k = 0; k < C; k++) drive_level(data[k], D);
        drive_level(stop_bit, D);
    endtask

    function automatic logic model_sample(input int idx);
`ifdef SIPO_MAJORITY_VOTE_EN
        int ones;
        ones = int'(pin_hist[idx - 1]) + int'(pin_hist[idx]) + int'(pin_hist[idx + 1]);
        return (ones >= 2);
`else
        return pin_hist[idx];
`endif
    endfunction

    // Decode the frame whose start edge was captured at t0 from the line history
    task automatic model_frame(input int t0, output logic started, output logic [7:0] data,
                               output logic stop_ok, output int pulse_cyc);
        started = !model_sample(t0 + D / 2);
        for (int k = 0; k < C; k++) data[k] = model_sample(t0 + D / 2 + (k + 1) * D);
        stop_ok   = model_sample(t0 + D / 2 + (C + 1) * D);
        pulse_cyc = t0 + 3 + D / 2 + (C + 1) * D + LAT;
    endtask

    task automatic find_events(input int lo, input int hi,
                               output int nv, output int vc0, output logic [7:0] vd0,
                               output int vc1, output logic [7:0] vd1,
                               output int nfe, output int fc0);
        nv = 0; nfe = 0; vc0 = -1; vc1 = -1; vd0 = 8'h00; vd1 = 8'h00; fc0 = -1;
        foreach (v_cyc[i]) begin
            if (v_cyc[i] >= lo && v_cyc[i] <= hi) begin
                if (nv == 0) begin vc0 = v_cyc[i]; vd0 = v_dat[i]; end
                vc1 = v_cyc[i]; vd1 = v_dat[i];
                nv++;
            end
        end
        foreach (fe_cyc[i]) begin
            if (fe_cyc[i] >= lo && fe_cyc[i] <= hi) begin
                if (nfe == 0) fc0 = fe_cyc[i];
                nfe++;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_level(1'b1, 4);
        checks++; if (bus.rx_data !== 8'h00) begin fails++; $display("[TB] FAIL reset_rx_data: got %0h, expected 0", bus.rx_data); end
        checks++; if (bus.rx_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_rx_valid: got %b, expected 0", bus.rx_valid); end
        checks++; if (bus.framing_error !== 1'b0) begin fails++; $display("[TB] FAIL reset_framing_error: got %b, expected 0", bus.framing_error); end
        checks++; if (bus.rx_busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_rx_busy: got %b, expected 0", bus.rx_busy); end
        reset = 1'b0;
        drive_level(1'b1, 8);
    endtask

    task automatic test_single_frame();
        int t0, pc, nv, vc0, vc1, nfe, fc0;
        logic st, sok;
        logic [7:0] md, vd0, vd1;
        send_frame(8'h1A, 1'b1, t0);
        drive_level(1'b1, 40);
        model_frame(t0, st, md, sok, pc);
        find_events(t0, cyc, nv, vc0, vd0, vc1, vd1, nfe, fc0);
        checks++; if (nv !== 1) begin fails++; $display("[TB] FAIL single_valid_count: got %0d, expected 1", nv); end
        checks++; if (vc0 !== pc) begin fails++; $display("[TB] FAIL single_valid_cycle: got t0+%0d, expected t0+%0d", vc0 - t0, pc - t0); end
        checks++; if (vd0 !== md) begin fails++; $display("[TB] FAIL single_data: got %0h, expected %0h", vd0, md); end
        checks++; if (nfe !== 0) begin fails++; $display("[TB] FAIL single_no_ferr: got %0d pulses, expected 0", nfe); end
        checks++; if (busy_hist[t0 + 2] !== 1'b0) begin fails++; $display("[TB] FAIL single_busy_t0p2: got %b, expected 0", busy_hist[t0 + 2]); end
        checks++; if (busy_hist[t0 + 3] !== 1'b1) begin fails++; $display("[TB] FAIL single_busy_t0p3: got %b, expected 1", busy_hist[t0 + 3]); end
        checks++; if (busy_hist[pc] !== 1'b0) begin fails++; $display("[TB] FAIL single_busy_at_pulse: got %b, expected 0", busy_hist[pc]); end
        checks++; if (bus.rx_data !== md) begin fails++; $display("[TB] FAIL single_data_hold: got %0h, expected %0h", bus.rx_data, md); end
        last_good = md;
    endtask

    task automatic test_back_to_back();
        int ta, tb, pa, pb, nv, vc0, vc1, nfe, fc0;
        logic st, sok;
        logic [7:0] ma, mb, vd0, vd1;
        send_frame(8'h00, 1'b1, ta);
        send_frame(8'hFF, 1'b1, tb);
        drive_level(1'b1, 40);
        model_frame(ta, st, ma, sok, pa);
        model_frame(tb, st, mb, sok, pb);
        find_events(ta, cyc, nv, vc0, vd0, vc1, vd1, nfe, fc0);
        checks++; if (nv !== 2) begin fails++; $display("[TB] FAIL b2b_valid_count: got %0d, expected 2", nv); end
        checks++; if (vc0 !== pa) begin fails++; $display("[TB] FAIL b2b_first_cycle: got %0d, expected %0d", vc0, pa); end
        checks++; if (vc1 - vc0 !== pb - pa) begin fails++; $display("[TB] FAIL b2b_spacing: got %0d, expected %0d", vc1 - vc0, pb - pa); end
        checks++; if (vd0 !== ma) begin fails++; $display("[TB] FAIL b2b_first_data: got %0h, expected %0h", vd0, ma); end
        checks++; if (vd1 !== mb) begin fails++; $display("[TB] FAIL b2b_second_data: got %0h, expected %0h", vd1, mb); end
        last_good = mb;
    endtask

    task automatic test_start_glitch();
        int t0, nv, vc0, vc1, nfe, fc0;
        logic [7:0] vd0, vd1;
        t0 = cyc + 1;
        drive_level(1'b0, 4);
        drive_level(1'b1, 40);
        find_events(t0, cyc, nv, vc0, vd0, vc1, vd1, nfe, fc0);
        checks++; if (nv !== 0) begin fails++; $display("[TB] FAIL glitch_no_valid: got %0d pulses, expected 0", nv); end
        checks++; if (nfe !== 0) begin fails++; $display("[TB] FAIL glitch_no_ferr: got %0d pulses, expected 0", nfe); end
        checks++; if (busy_hist[t0 + 10 + LAT] !== 1'b1) begin fails++; $display("[TB] FAIL glitch_busy_before_drop: got %b, expected 1", busy_hist[t0 + 10 + LAT]); end
        checks++; if (busy_hist[t0 + 11 + LAT] !== 1'b0) begin fails++; $display("[TB] FAIL glitch_busy_drop: got %b, expected 0", busy_hist[t0 + 11 + LAT]); end
        checks++; if (bus.rx_data !== last_good) begin fails++; $display("[TB] FAIL glitch_data_hold: got %0h, expected %0h", bus.rx_data, last_good); end
    endtask

    task automatic test_framing_error();
        int t0, t1, pc, p1, nv, vc0, vc1, nfe, fc0, busy_hits;
        logic st, sok;
        logic [7:0] md, m1, vd0, vd1, rnd;
        send_frame(8'h55, 1'b0, t0);
        drive_level(1'b0, 64);
        drive_level(1'b1, 40);
        model_frame(t0, st, md, sok, pc);
        find_events(t0, cyc, nv, vc0, vd0, vc1, vd1, nfe, fc0);
        checks++; if (nfe !== (sok ? 0 : 1)) begin fails++; $display("[TB] FAIL ferr_count: got %0d, expected %0d", nfe, sok ? 0 : 1); end
        checks++; if (fc0 !== pc) begin fails++; $display("[TB] FAIL ferr_cycle: got %0d, expected %0d", fc0, pc); end
        checks++; if (nv !== 0) begin fails++; $display("[TB] FAIL ferr_no_valid: got %0d pulses, expected 0", nv); end
        checks++; if (bus.rx_data !== last_good) begin fails++; $display("[TB] FAIL ferr_data_hold: got %0h, expected %0h", bus.rx_data, last_good); end
        busy_hits = 0;
        for (int c = pc; c <= cyc; c++) if (busy_hist[c] !== 1'b0) busy_hits++;
        checks++; if (busy_hits !== 0) begin fails++; $display("[TB] FAIL ferr_no_retrigger: got %0d busy cycles, expected 0", busy_hits); end
        rnd = 8'($urandom);
        send_frame(rnd, 1'b1, t1);
        drive_level(1'b1, 30);
        model_frame(t1, st, m1, sok, p1);
        find_events(t1, cyc, nv, vc0, vd0, vc1, vd1, nfe, fc0);
        checks++; if (vd0 !== m1 || vc0 !== p1) begin fails++; $display("[TB] FAIL ferr_recovery: got %0h at %0d, expected %0h at %0d", vd0, vc0, m1, p1); end
        last_good = m1;
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] f;
        int t1, p1, nv, vc0, vc1, nfe, fc0;
        logic st, sok;
        logic [7:0] m1, vd0, vd1;
        f = 8'hA5;
        drive_level(1'b0, D);
        for (int k = 0; k < 3; k++) drive_level(f[k], D);
        drive_level(f[3], 8);
        reset = 1'b1;
        drive_level(f[3], 1);
        checks++; if (bus.rx_data !== 8'h00) begin fails++; $display("[TB] FAIL midreset_rx_data: got %0h, expected 0", bus.rx_data); end
        checks++; if (bus.rx_valid !== 1'b0 || bus.framing_error !== 1'b0) begin fails++; $display("[TB] FAIL midreset_pulses: got %b%b, expected 00", bus.rx_valid, bus.framing_error); end
        checks++; if (bus.rx_busy !== 1'b0) begin fails++; $display("[TB] FAIL midreset_rx_busy: got %b, expected 0", bus.rx_busy); end
        reset = 1'b0;
        drive_level(f[3], 7);
        for (int k = 4; k < C; k++) drive_level(f[k], D);
        drive_level(1'b1, D);
        drive_level(1'b1, 220);
        send_frame(8'h3C, 1'b1, t1);
        drive_level(1'b1, 30);
        model_frame(t1, st, m1, sok, p1);
        find_events(t1, cyc, nv, vc0, vd0, vc1, vd1, nfe, fc0);
        checks++; if (nv !== 1 || vc0 !== p1) begin fails++; $display("[TB] FAIL midreset_next_pulse: got %0d at %0d, expected 1 at %0d", nv, vc0, p1); end
        checks++; if (vd0 !== m1) begin fails++; $display("[TB] FAIL midreset_next_data: got %0h, expected %0h", vd0, m1); end
        last_good = m1;
    endtask

    task automatic test_vote_glitch();
        logic [7:0] f, want, md, vd0, vd1;
        int t0, pc, nv, vc0, vc1, nfe, fc0;
        logic st, sok;
        f = 8'h0F;
        t0 = cyc + 1;
        drive_level(1'b0, D);
        for (int k = 0; k < C; k++) begin
            drive_level(f[k], D / 2);
            drive_level(!f[k], 1);
            drive_level(f[k], D / 2 - 1);
        end
        drive_level(1'b1, D);
        drive_level(1'b1, 30);
        model_frame(t0, st, md, sok, pc);
`ifdef SIPO_MAJORITY_VOTE_EN
        want = 8'h0F;
`else
        want = 8'hF0;
`endif
        find_events(t0, cyc, nv, vc0, vd0, vc1, vd1, nfe, fc0);
        checks++; if (nv !== 1 || vc0 !== pc) begin fails++; $display("[TB] FAIL vote_pulse: got %0d at %0d, expected 1 at %0d", nv, vc0, pc); end
        checks++; if (vd0 !== md) begin fails++; $display("[TB] FAIL vote_model_data: got %0h, expected %0h", vd0, md); end
        checks++; if (vd0 !== want) begin fails++; $display("[TB] FAIL vote_data: got %0h, expected %0h", vd0, want); end
        last_good = md;
    endtask

    task automatic test_random_frames();
        int t0s [8];
        int pc, nv, vc0, vc1, nfe, fc0;
        logic st, sok;
        logic [7:0] md, vd0, vd1;
        for (int i = 0; i < 8; i++) begin
            send_frame(8'($urandom), 1'b1, t0s[i]);
            drive_level(1'b1, ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 20));
        end
        drive_level(1'b1, 40);
        for (int i = 0; i < 8; i++) begin
            model_frame(t0s[i], st, md, sok, pc);
            find_events(t0s[i], t0s[i] + 165, nv, vc0, vd0, vc1, vd1, nfe, fc0);
            checks++; if (nv !== 1) begin fails++; $display("[TB] FAIL rand%0d_count: got %0d, expected 1", i, nv); end
            checks++; if (vc0 !== pc) begin fails++; $display("[TB] FAIL rand%0d_cycle: got %0d, expected %0d", i, vc0, pc); end
            checks++; if (vd0 !== md) begin fails++; $display("[TB] FAIL rand%0d_data: got %0h, expected %0h", i, vd0, md); end
        end
    endtask

    // Run every scenario in order, then report
    initial begin
        reset = 1'b1;
        bus.uart_rx_pin = 1'b1;
        for (int i = 0; i < MAXC; i++) begin
            pin_hist[i]  = 1'b1;
            busy_hist[i] = 1'b0;
        end
        @(posedge clock_50M);
        #1;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_start_glitch();
        test_framing_error();
        test_reset_mid_frame();
        test_vote_glitch();
        test_random_frames();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
